// File: rtl/data_stack.sv
// j2 data stack: T register plus a DEPTH-entry array behind it.
// T and N feed the ALU. Each executed instruction updates the stack according to its stack-effect fields.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  logic [15:0]              instruction,
    input  logic [WIDTH-1:0]         data_stack_next_value,
    output logic [WIDTH-1:0]         data_stack_current_top,
    output logic [WIDTH-1:0]         data_stack_current_next_top,
    output logic [$clog2(DEPTH)-1:0] dsp,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] DSP_MAX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] t_q, t_d;
    logic [PW-1:0]    dsp_q, dsp_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [PW-1:0]    dsp_inc, dsp_dec1, dsp_dec2;
    logic [WIDTH-1:0] n_val;
    logic             unused_fields;

    // Only the class, T->N and delta fields matter to the data stack.
    assign unused_fields = ^{instruction[12:8], instruction[6:2]};

    assign n_val    = mem[dsp_q];
    assign dsp_inc  = dsp_q + PW'(1);
    assign dsp_dec1 = dsp_q - PW'(1);
    assign dsp_dec2 = dsp_q - PW'(2);

    always_comb begin
        t_d         = t_q;
        dsp_d       = dsp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = dsp_q;
        if (step) begin
            if (instruction[15]) begin
                wr_en   = 1'b1;
                wr_addr = dsp_inc;
                dsp_d   = dsp_inc;
                t_d     = data_stack_next_value;
                if (dsp_q == DSP_MAX) overflow_d = 1'b1;
            end else begin
                case (instruction[14:13])
                    2'b01: begin
                        t_d   = n_val;
                        dsp_d = dsp_dec1;
                        if (dsp_q == '0) underflow_d = 1'b1;
                    end
                    2'b11: begin
                        t_d = data_stack_next_value;
                        case (instruction[1:0])
                            2'b01: begin
                                dsp_d = dsp_inc;
                                if (dsp_q == DSP_MAX) overflow_d = 1'b1;
                            end
                            2'b10: begin
                                dsp_d = dsp_dec2;
                                if (dsp_q <= PW'(1)) underflow_d = 1'b1;
                            end
                            2'b11: begin
                                dsp_d = dsp_dec1;
                                if (dsp_q == '0) underflow_d = 1'b1;
                            end
                            default: dsp_d = dsp_q;
                        endcase
                        // Old T lands at the post-delta pointer so the next N sees it.
                        wr_en   = instruction[7] | (instruction[1:0] == 2'b01);
                        wr_addr = dsp_d;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q         <= '0;
            dsp_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            t_q         <= t_d;
            dsp_q       <= dsp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem[wr_addr] <= t_q;
    end

    assign data_stack_current_top      = t_q;
    assign data_stack_current_next_top = n_val;
    assign dsp                         = dsp_q;
    assign overflow                    = overflow_q;
    assign underflow                   = underflow_q;
endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: inputs change on the falling edge, and outputs are checked at the next falling edge.
module tb_data_stack;
    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic [15:0] instruction;
    logic [15:0] nv;
    logic [15:0] t, n;
    logic [3:0]  dsp;
    logic        overflow, underflow;
    int          n_checks = 0;
    int          n_fail = 0;

    data_stack #(.WIDTH(16), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .step(step), .instruction(instruction),
        .data_stack_next_value(nv), .data_stack_current_top(t),
        .data_stack_current_next_top(n), .dsp(dsp),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic exec(input logic [15:0] ins, input logic [15:0] val);
        step = 1'b1; instruction = ins; nv = val;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step = 1'b1; instruction = 16'h8000; nv = 16'h1111;
        @(negedge clk);
        reset = 1'b0; step = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 4;
        if (t !== 16'h0)    begin n_fail++; $display("FAIL reset_T got %h want 0000", t); end
        if (dsp !== 4'd0)   begin n_fail++; $display("FAIL reset_dsp got %0d want 0", dsp); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b want 0", underflow); end
    endtask

    task automatic test_literals();
        exec(16'h8000, 16'h1234);
        exec(16'h8000, 16'h0055);
        n_checks += 3;
        if (t !== 16'h0055) begin n_fail++; $display("FAIL lit_T got %h want 0055", t); end
        if (n !== 16'h1234) begin n_fail++; $display("FAIL lit_N got %h want 1234", n); end
        if (dsp !== 4'd2)   begin n_fail++; $display("FAIL lit_dsp got %0d want 2", dsp); end
        exec(16'h6203, 16'h1289);
        n_checks += 3;
        if (t !== 16'h1289) begin n_fail++; $display("FAIL alu_dec_T got %h want 1289", t); end
        if (dsp !== 4'd1)   begin n_fail++; $display("FAIL alu_dec_dsp got %0d want 1", dsp); end
        if (n !== 16'h0000) begin n_fail++; $display("FAIL alu_dec_N got %h want 0000", n); end
        exec(16'h2000, 16'hDEAD);
        n_checks += 2;
        if (t !== 16'h0000) begin n_fail++; $display("FAIL cjmp_T got %h want 0000", t); end
        if (dsp !== 4'd0)   begin n_fail++; $display("FAIL cjmp_dsp got %0d want 0", dsp); end
    endtask

    task automatic test_alu_tn();
        exec(16'h80AA, 16'h00AA);
        exec(16'h6080, 16'hBEEF);
        n_checks += 3;
        if (t !== 16'hBEEF) begin n_fail++; $display("FAIL tn_T got %h want beef", t); end
        if (n !== 16'h00AA) begin n_fail++; $display("FAIL tn_N got %h want 00aa", n); end
        if (dsp !== 4'd1)   begin n_fail++; $display("FAIL tn_dsp got %0d want 1", dsp); end
        exec(16'h0000, 16'hFFFF);
        exec(16'h4000, 16'hFFFF);
        n_checks += 3;
        if (t !== 16'hBEEF) begin n_fail++; $display("FAIL jmp_T got %h want beef", t); end
        if (n !== 16'h00AA) begin n_fail++; $display("FAIL jmp_N got %h want 00aa", n); end
        if (dsp !== 4'd1)   begin n_fail++; $display("FAIL jmp_dsp got %0d want 1", dsp); end
        exec(16'h6001, 16'h0777);
        n_checks += 3;
        if (t !== 16'h0777) begin n_fail++; $display("FAIL inc_T got %h want 0777", t); end
        if (n !== 16'hBEEF) begin n_fail++; $display("FAIL inc_N got %h want beef", n); end
        if (dsp !== 4'd2)   begin n_fail++; $display("FAIL inc_dsp got %0d want 2", dsp); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) exec(16'h8000, 16'(i));
        n_checks += 5;
        if (dsp !== 4'd0)        begin n_fail++; $display("FAIL ovf_dsp got %0d want 0", dsp); end
        if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        if (underflow !== 1'b0)  begin n_fail++; $display("FAIL ovf_unf got %b want 0", underflow); end
        if (t !== 16'd15)        begin n_fail++; $display("FAIL ovf_T got %h want 000f", t); end
        if (n !== 16'd14)        begin n_fail++; $display("FAIL ovf_N got %h want 000e", n); end
        exec(16'h8000, 16'h0099);
        exec(16'h6000, 16'h0098);
        n_checks += 2;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        if (dsp !== 4'd1)      begin n_fail++; $display("FAIL ovf_after_dsp got %0d want 1", dsp); end
    endtask

    task automatic test_underflow();
        do_reset();
        exec(16'h6002, 16'h0042);
        n_checks += 4;
        if (dsp !== 4'd14)      begin n_fail++; $display("FAIL unf2_dsp got %0d want 14", dsp); end
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf2_flag got %b want 1", underflow); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL unf2_ovf got %b want 0", overflow); end
        if (t !== 16'h0042)     begin n_fail++; $display("FAIL unf2_T got %h want 0042", t); end
        exec(16'h6000, 16'h0043);
        exec(16'h2000, 16'h0044);
        n_checks += 2;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got %b want 1", underflow); end
        if (dsp !== 4'd13)      begin n_fail++; $display("FAIL unf_after_dsp got %0d want 13", dsp); end
        do_reset();
        exec(16'h2000, 16'h0000);
        n_checks += 2;
        if (dsp !== 4'd15)      begin n_fail++; $display("FAIL pop0_dsp got %0d want 15", dsp); end
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL pop0_flag got %b want 1", underflow); end
        do_reset();
        exec(16'h6001, 16'h0001);
        exec(16'h6002, 16'h0002);
        n_checks += 2;
        if (dsp !== 4'd15)      begin n_fail++; $display("FAIL dec2_from1_dsp got %0d want 15", dsp); end
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL dec2_from1_flag got %b want 1", underflow); end
    endtask

    task automatic test_hold();
        do_reset();
        exec(16'h8000, 16'h00C3);
        for (int i = 0; i < 5; i++) begin
            step = 1'b0; instruction = 16'h8000 ^ 16'(i * 16'h1357); nv = 16'(16'hA5A5 + i);
            @(negedge clk);
            n_checks += 4;
            if (t !== 16'h00C3) begin n_fail++; $display("FAIL hold_T[%0d] got %h want 00c3", i, t); end
            if (n !== 16'h0000) begin n_fail++; $display("FAIL hold_N[%0d] got %h want 0000", i, n); end
            if (dsp !== 4'd1)   begin n_fail++; $display("FAIL hold_dsp[%0d] got %0d want 1", i, dsp); end
            if (overflow !== 1'b0 || underflow !== 1'b0)
                begin n_fail++; $display("FAIL hold_flags[%0d] got %b%b want 00", i, overflow, underflow); end
        end
    endtask

    task automatic test_reset_priority();
        exec(16'h6002, 16'h7777);
        reset = 1'b1; step = 1'b1; instruction = 16'h6081; nv = 16'h5555;
        @(negedge clk);
        reset = 1'b0; step = 1'b0;
        n_checks += 4;
        if (t !== 16'h0)        begin n_fail++; $display("FAIL rstpri_T got %h want 0000", t); end
        if (dsp !== 4'd0)       begin n_fail++; $display("FAIL rstpri_dsp got %0d want 0", dsp); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL rstpri_ovf got %b want 0", overflow); end
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL rstpri_unf got %b want 0", underflow); end
    endtask

    initial begin
        reset = 1'b0; step = 1'b0; instruction = 16'h0; nv = 16'h0;
        test_reset();
        test_literals();
        test_alu_tn();
        test_overflow();
        test_underflow();
        test_hold();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_stack.md
# data_stack

Data stack for the j2 core: holds the top-of-stack register T and a DEPTH-entry array behind it, and presents T and N (next-on-stack) to the ALU. It sits on the other side of the ALU datapath: it sources the ALU's stack operands and accepts the ALU result. It also decodes the stack-effect fields of the current instruction to update T, the array and the stack pointer once per executed instruction. It reports wrap-around of the stack pointer through sticky overflow/underflow flags.

## Interface
- WIDTH, default `WIDTH` (16): data word width.
- DEPTH, default 16: array entries; must be a power of two; the pointer is log2(DEPTH) bits and feeds the 4-bit dsp field of the ALU status word.
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- step  input  1  high for exactly the cycle in which `instruction` executes; no state change while low.
- instruction  input  16  instruction currently executing.
- data_stack_next_value  input  WIDTH  ALU result for this instruction.
- data_stack_current_top  output  WIDTH  T register.
- data_stack_current_next_top  output  WIDTH  N = array[dsp], combinational read.
- dsp  output  log2(DEPTH)  stack pointer.
- overflow  output  1  sticky; set by push wrap.
- underflow  output  1  sticky; set by pop wrap.

## Operation
- State: T register, dsp register, array[0..DEPTH-1], overflow and underflow flags. The array is not reset.
- Decode happens only when step=1. Class comes from instruction[15:13]:
  - 1xx literal: push. array[dsp+1] <= T; dsp <= dsp+1; T <= data_stack_next_value.
  - 000 jump and 010 call: no data-stack change.
  - 001 conditional jump: pop. T <= array[dsp], the current N; dsp <= dsp-1.
  - 011 ALU op: T <= data_stack_next_value. The delta comes from instruction[1:0] (2-bit signed): 00 → 0, 01 → +1, 10 → -2, 11 → -1.
- ALU-op array write:
  - T->N is instruction[7]. If instruction[7]=1 or delta=+1, array[dsp+delta] <= old T.
  - delta ≤ 0 with instruction[7]=0: no array write.
  - dsp <= dsp+delta.
- Pointer arithmetic is modulo DEPTH.
  - A +1 from dsp=DEPTH-1 wraps to 0 and sets overflow.
  - A -1 from dsp=0, or -2 from dsp<2, wraps and sets underflow.
  - Flags stay set until reset.
- The array write address always uses the pre-update dsp plus delta. One array write at most per cycle.
- Bits 6, 5, 4:2 and 12:8 have no data-stack effect in this block. Return stack, memory and I/O are handled elsewhere.

## Timing
- Outputs are registered state: T and dsp come straight from flops; N is a combinational read of array[dsp].
- Zero-cycle operand path: the ALU sees T/N during the step cycle. The result is committed at that cycle's rising edge. Next-cycle T/N reflect the new state, including a same-edge array write at the new dsp.
- Reset values: T=0, dsp=0, overflow=0, underflow=0. data_stack_current_next_top is undefined until written; the bench must not check it.
- Reset has priority over step in the same cycle. Reset mid-program discards the instruction in flight; the array contents survive but are unspecified.
- step low for any number of cycles: all state and outputs are held.
- Back-to-back steps are supported every cycle; there are no stalls.

## Test plan
- Reset: assert reset 1 cycle with step=1 and a literal → T=0, dsp=0, overflow=0, underflow=0.
- Two literals (next_value 0x1234, then 0x0055) → T=0x0055, N=0x1234, dsp=2, array[1]=0x0000.
- Then ALU op 0x6203 (delta -1) with next_value 0x1289 → T=0x1289, dsp=1, N=0x0000. Then conditional jump 0x2000 → T=0x0000, dsp=0.
- ALU op with bit7=1, delta 0, next_value 0xBEEF while T=0x00AA → array[dsp]=0x00AA, N=0x00AA, T=0xBEEF, dsp unchanged. A jump/call (0x0000/0x4000) with next_value 0xFFFF → T, N, dsp unchanged.
- Overflow and underflow:
  - From reset, 16 literal pushes → dsp=0, overflow=1, underflow=0.
  - After a reset, one ALU op with delta -2 → dsp=14, underflow=1.
  - Both flags stay set through further instructions until reset.
- step=0 for 5 cycles with changing instruction/next_value → no output change. Reset asserted together with step and an ALU op → reset values win.
